// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard control unit: FSM encoding, forward selects
// and the shadow stage tuple tracked for EX/MEM/WB.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HOLD  = 2'b11
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       load;
    logic       modify_cc;
  } stage_t;

  // %g0 is hardwired, so a stage targeting it never produces a value
  function automatic logic writes_reg(stage_t st, logic [4:0] rs);
    return st.we && (st.rd != 5'd0) && (st.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Operand forward-select: picks the youngest in-flight producer of rs.
module fwd_select
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  stage_t     ex,
  input  stage_t     mem,
  input  stage_t     wb,
  output logic [1:0] sel
);

  // A load in EX has no data yet; the stall logic covers it, so no bypass
  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (writes_reg(ex, rs))       sel = ex.load ? FWD_RF : FWD_EX;
      else if (writes_reg(mem, rs)) sel = FWD_MEM;
      else if (writes_reg(wb, rs))  sel = FWD_WB;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ex.modify_cc, mem.load, mem.modify_cc, wb.load, wb.modify_cc};

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use/CC stall FSM, external hold, operand
// forwarding from shadow EX/MEM/WB tuples and a saturating bubble counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        R,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_rs1_used,
  input  logic        ID_rs2_used,
  input  logic [4:0]  ID_rd,
  input  logic        ID_RF_enable,
  input  logic        ID_load_instr,
  input  logic        ID_modifyCC,
  input  logic        ID_B_instr,
  input  logic        hold,
  output logic        LE,
  output logic        S,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count
);

  state_t state_reg, state_next;
  stage_t ex_reg, mem_reg, wb_reg;
  stage_t id_stage;
  logic   load_use, cc_hazard, hazard;

  assign id_stage = '{rd: ID_rd, we: ID_RF_enable, load: ID_load_instr, modify_cc: ID_modifyCC};

  assign load_use  = ex_reg.load && ((ID_rs1_used && writes_reg(ex_reg, ID_rs1)) ||
                                     (ID_rs2_used && writes_reg(ex_reg, ID_rs2)));
  assign cc_hazard = ID_B_instr && ex_reg.modify_cc;
  assign hazard    = load_use || cc_hazard;

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_reg   <= INIT;
      ex_reg      <= '0;
      mem_reg     <= '0;
      wb_reg      <= '0;
      stall_count <= '0;
    end else begin
      state_reg <= state_next;
      ex_reg    <= S ? '0 : id_stage;
      mem_reg   <= ex_reg;
      wb_reg    <= mem_reg;
      if (S && (state_reg != INIT) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  // hold outranks hazards; STALL always releases because the bubble is in EX
  always_comb begin
    state_next = state_reg;
    LE         = 1'b1;
    S          = 1'b0;
    case (state_reg)
      INIT: begin
        S          = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (hold) begin
          LE         = 1'b0;
          S          = 1'b1;
          state_next = HOLD;
        end else if (hazard) begin
          LE         = 1'b0;
          S          = 1'b1;
          state_next = STALL;
        end
      end
      STALL: begin
        state_next = hold ? HOLD : RUN;
      end
      HOLD: begin
        LE         = 1'b0;
        S          = 1'b1;
        state_next = hold ? HOLD : RUN;
      end
      default: state_next = INIT;
    endcase
  end

  fwd_select u_fwd_a (
    .rs   (ID_rs1),
    .used (ID_rs1_used),
    .ex   (ex_reg),
    .mem  (mem_reg),
    .wb   (wb_reg),
    .sel  (fwd_a)
  );

  fwd_select u_fwd_b (
    .rs   (ID_rs2),
    .used (ID_rs2_used),
    .ex   (ex_reg),
    .mem  (mem_reg),
    .wb   (wb_reg),
    .sel  (fwd_b)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomised + directed bench for hazard_control_unit against an issue-history model.
module tb_hazard_control_unit;

  logic        Clk = 1'b0;
  logic        R   = 1'b0;
  logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
  logic        ID_rs1_used = 1'b0, ID_rs2_used = 1'b0;
  logic        ID_RF_enable = 1'b0, ID_load_instr = 1'b0, ID_modifyCC = 1'b0, ID_B_instr = 1'b0;
  logic        hold = 1'b0;
  logic        LE, S;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  hazard_control_unit dut (
    .Clk(Clk), .R(R),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd(ID_rd), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
    .ID_modifyCC(ID_modifyCC), .ID_B_instr(ID_B_instr), .hold(hold),
    .LE(LE), .S(S), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  // Model: the last three issued instructions (index 0 = youngest) and a mode
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mcc;
  } ins_t;

  localparam int M_INIT = 0, M_RUN = 1, M_STALL = 2, M_HOLD = 3;

  ins_t        hist [3] = '{default: '0};
  int          m_mode   = M_INIT;
  logic [15:0] m_count  = '0;

  function automatic bit m_hazard();
    bit lu;
    lu = hist[0].ld && hist[0].we && (hist[0].rd != 0) &&
         ((ID_rs1_used && ID_rs1 == hist[0].rd) || (ID_rs2_used && ID_rs2 == hist[0].rd));
    return lu || (ID_B_instr && hist[0].mcc);
  endfunction

  function automatic bit m_s();
    case (m_mode)
      M_INIT:  return 1'b1;
      M_RUN:   return hold || m_hazard();
      M_STALL: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_le();
    case (m_mode)
      M_INIT:  return 1'b1;
      M_RUN:   return !(hold || m_hazard());
      M_STALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_next();
    case (m_mode)
      M_INIT:  return M_RUN;
      M_RUN:   return hold ? M_HOLD : (m_hazard() ? M_STALL : M_RUN);
      default: return hold ? M_HOLD : M_RUN;
    endcase
  endfunction

  // -1 means don't care: EX load producing the operand (the stall handles it)
  function automatic int m_fwd(logic [4:0] rs, logic used);
    if (!used || rs == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (hist[k].we && hist[k].rd == rs) return (k == 0 && hist[0].ld) ? -1 : k + 1;
    return 0;
  endfunction

  always @(posedge Clk or negedge R) begin
    if (!R) begin
      m_mode  <= M_INIT;
      m_count <= '0;
      hist    <= '{default: '0};
    end else begin
      m_count <= (m_s() && m_mode != M_INIT && m_count != 16'hFFFF) ? m_count + 16'd1 : m_count;
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= m_s() ? ins_t'(0) : ins_t'{ID_rd, ID_RF_enable, ID_load_instr, ID_modifyCC};
      m_mode  <= m_next();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int fa, fb;
    chk("model_LE", LE, m_le());
    chk("model_S", S, m_s());
    chk("model_stall_count", stall_count, m_count);
    fa = m_fwd(ID_rs1, ID_rs1_used);
    fb = m_fwd(ID_rs2, ID_rs2_used);
    if (fa >= 0) chk("model_fwd_a", fwd_a, fa);
    if (fb >= 0) chk("model_fwd_b", fwd_b, fb);
  endtask

  task automatic apply(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld, input logic mcc,
                       input logic br, input logic hld);
    @(negedge Clk);
    ID_rs1 = rs1; ID_rs1_used = u1; ID_rs2 = rs2; ID_rs2_used = u2;
    ID_rd = rd; ID_RF_enable = we; ID_load_instr = ld; ID_modifyCC = mcc;
    ID_B_instr = br; hold = hld;
    #1;
    model_check();
    $display("[TB] t=%0t rs1=%0d/%0d rs2=%0d/%0d rd=%0d we=%0d ld=%0d cc=%0d b=%0d hold=%0d -> LE=%0d S=%0d fa=%0d fb=%0d cnt=%0d",
             $time, rs1, u1, rs2, u2, rd, we, ld, mcc, br, hld, LE, S, fwd_a, fwd_b, stall_count);
  endtask

  task automatic nop(input logic hld);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, hld);
  endtask

  initial begin
    int guard;
    #3 R = 1'b1;
    #1;
    chk("reset_S", S, 1);
    chk("reset_LE", LE, 1);
    chk("reset_count", stall_count, 0);
    chk("reset_fwd_a", fwd_a, 0);
    chk("reset_fwd_b", fwd_b, 0);

    nop(0);
    chk("run_LE", LE, 1);
    chk("run_S", S, 0);
    chk("run_count", stall_count, 0);

    // load-use: load r5 then a reader of r5
    apply(0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    apply(5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    chk("lu_LE", LE, 0);
    chk("lu_S", S, 1);
    apply(5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    chk("lu_stall_LE", LE, 1);
    chk("lu_stall_S", S, 0);
    chk("lu_fwd_a_mem", fwd_a, 2);
    chk("lu_count", stall_count, 1);

    // youngest producer wins: EX and WB both write r5
    nop(0);
    apply(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    nop(0);
    apply(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    apply(0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("young_fwd_b_ex", fwd_b, 1);
    chk("young_S", S, 0);

    // writes to %g0 never forward or stall
    apply(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("g0_fwd_a", fwd_a, 0);
    chk("g0_S", S, 0);

    // CC hazard, then hold for three cycles
    apply(0, 0, 0, 0, 7, 1, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("cc_LE", LE, 0);
    chk("cc_S", S, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("cc_stall_S", S, 0);
    chk("cc_count", stall_count, 2);
    nop(1);
    chk("hold1_S", S, 1);
    chk("hold1_LE", LE, 0);
    nop(1);
    chk("hold2_S", S, 1);
    nop(0);
    chk("hold3_S", S, 1);
    nop(0);
    chk("hold_back_LE", LE, 1);
    chk("hold_back_S", S, 0);
    chk("hold_count", stall_count, 5);

    // random traffic over a small register window to provoke matches
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    // drive the counter to saturation with a long hold
    nop(1);
    guard = 0;
    while (m_count != 16'hFFFF && guard < 70000) begin
      @(posedge Clk);
      #1;
      guard++;
    end
    chk("sat_reached_in_budget", guard < 70000, 1);
    nop(0);
    chk("sat_count_hold", stall_count, 16'hFFFF);
    apply(0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    apply(0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_lu_S", S, 1);
    apply(0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_count_stall", stall_count, 16'hFFFF);

    // reset in the middle of a hold clears everything
    apply(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    apply(9, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("prehold_fwd_a", fwd_a, 1);
    chk("prehold_S", S, 1);
    @(negedge Clk);
    R = 1'b0;
    #1;
    chk("midhold_rst_fwd_a", fwd_a, 0);
    chk("midhold_rst_S", S, 1);
    chk("midhold_rst_LE", LE, 1);
    chk("midhold_rst_count", stall_count, 0);
    @(negedge Clk);
    R = 1'b1;
    nop(0);
    apply(9, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_fwd_a", fwd_a, 0);
    chk("post_rst_S", S, 0);
    chk("post_rst_count", stall_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
